// File: rtl/adc_fe_pkg.sv
// Shared types and width helpers for the ADC lane front-end.
// No logic and no latency. Nothing in this file needs backpressure.
package adc_fe_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SETTLE = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } deser_state_e;

  // bits needed to hold the values 0..max_val
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // bits needed to index n positions
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_deser_shift.sv
// Serial-to-word shifter with a one-cycle boundary hold on slip; word is out 1 cycle after its last bit.
// No backpressure: words are produced free-running whatever the caller does.
module adc_deser_shift
  import adc_fe_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              dco_clk,
  input  logic              rst_n,
  input  logic              ser_in,
  input  logic              fco_in,
  input  logic              slip,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_out,
  output logic              fco_out
);

  localparam int CW = idx_w(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  // the oldest bit never survives into a word, so only DATA_W-1 bits are kept
  logic [DATA_W-2:0] sr;
  logic [CW-1:0]     bit_cnt;

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      word_out   <= '0;
      fco_out    <= 1'b0;
    end else begin
      sr         <= {sr[DATA_W-3:0], ser_in};
      fco_out    <= fco_in;
      word_valid <= 1'b0;
      if (slip) begin
        bit_cnt <= bit_cnt;
      end else if (bit_cnt == LAST_BIT) begin
        bit_cnt    <= '0;
        word_out   <= {sr, ser_in};
        word_valid <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_deser_bitslip.sv
// Word-alignment FSM for one ADC lane: hunts TRAIN_PATTERN by bit-slipping, 1-cycle word latency.
// No backpressure; train_en freezes the FSM, relock restarts the hunt.
module adc_deser_bitslip
  import adc_fe_pkg::*;
#(
  parameter int                DATA_W        = 12,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DATA_W'(12'hA5C),
  parameter int                MATCH_COUNT   = 8,
  parameter int                SLIP_SETTLE   = 2
) (
  input  logic                      dco_clk,
  input  logic                      rst_n,
  input  logic                      ser_in,
  input  logic                      fco_in,
  input  logic                      train_en,
  input  logic                      relock,
  output logic                      word_valid,
  output logic [DATA_W-1:0]         word_out,
  output logic                      fco_out,
  output logic                      locked,
  output logic [$clog2(DATA_W)-1:0] slip_count,
  output logic                      lock_fail_pulse
);

  localparam int SCW = $clog2(DATA_W);
  localparam int MCW = cnt_w(MATCH_COUNT);
  localparam int STW = cnt_w(SLIP_SETTLE);
  localparam logic [SCW-1:0] SLIP_LAST   = SCW'(DATA_W - 1);
  localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_COUNT - 1);
  localparam logic [STW-1:0] SETTLE_LAST = (SLIP_SETTLE > 0) ? STW'(SLIP_SETTLE - 1) : '0;

  deser_state_e   state, state_nxt;
  logic [MCW-1:0] match_cnt, match_nxt;
  logic [STW-1:0] settle_cnt, settle_nxt;
  logic           slip;
  logic           eval;
  logic           hit;

  adc_deser_shift #(.DATA_W(DATA_W)) u_shift (
    .dco_clk    (dco_clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .fco_in     (fco_in),
    .slip       (slip),
    .word_valid (word_valid),
    .word_out   (word_out),
    .fco_out    (fco_out)
  );

  assign eval = word_valid & train_en;
  assign hit  = (word_out == TRAIN_PATTERN);

  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    settle_nxt = settle_cnt;
    slip       = 1'b0;
    // relock wins over everything, including a slip due this cycle
    if (relock) begin
      state_nxt  = HUNT;
      match_nxt  = '0;
      settle_nxt = '0;
    end else begin
      case (state)
        HUNT: begin
          if (eval) begin
            if (hit) begin
              match_nxt = MCW'(1);
              state_nxt = (MATCH_COUNT == 1) ? LOCKED : VERIFY;
            end else begin
              slip       = 1'b1;
              match_nxt  = '0;
              settle_nxt = '0;
              state_nxt  = SETTLE;
            end
          end
        end
        SETTLE: begin
          if (SLIP_SETTLE == 0) begin
            if (train_en) state_nxt = HUNT;
          end else if (eval) begin
            settle_nxt = settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) state_nxt = HUNT;
          end
        end
        VERIFY: begin
          if (eval) begin
            if (hit) begin
              match_nxt = match_cnt + 1'b1;
              if (match_cnt == MATCH_LAST) state_nxt = LOCKED;
            end else begin
              slip       = 1'b1;
              match_nxt  = '0;
              settle_nxt = '0;
              state_nxt  = SETTLE;
            end
          end
        end
        LOCKED: begin
          state_nxt = LOCKED;
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= HUNT;
      match_cnt       <= '0;
      settle_cnt      <= '0;
      slip_count      <= '0;
      lock_fail_pulse <= 1'b0;
      locked          <= 1'b0;
    end else begin
      state           <= state_nxt;
      match_cnt       <= match_nxt;
      settle_cnt      <= settle_nxt;
      locked          <= (state_nxt == LOCKED);
      lock_fail_pulse <= slip && (slip_count == SLIP_LAST);
      if (slip) slip_count <= (slip_count == SLIP_LAST) ? '0 : slip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_deser_bitslip.sv
// Randomized bench for adc_deser_bitslip against a word-level reference model.
module tb_adc_deser_bitslip;

  localparam int          DW  = 12;
  localparam logic [11:0] PAT = 12'hA5C;
  localparam int          MC  = 8;
  localparam int          SS  = 2;
  localparam int MH = 0, MS = 1, MV = 2, ML = 3;

  logic        dco_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_in = 1'b0;
  logic        fco_in = 1'b0;
  logic        train_en = 1'b0;
  logic        relock = 1'b0;
  logic        word_valid;
  logic [11:0] word_out;
  logic        fco_out;
  logic        locked;
  logic [3:0]  slip_count;
  logic        lock_fail_pulse;

  always #5 dco_clk = ~dco_clk;

  adc_deser_bitslip #(
    .DATA_W(DW), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_SETTLE(SS)
  ) dut (
    .dco_clk(dco_clk), .rst_n(rst_n), .ser_in(ser_in), .fco_in(fco_in),
    .train_en(train_en), .relock(relock), .word_valid(word_valid),
    .word_out(word_out), .fco_out(fco_out), .locked(locked),
    .slip_count(slip_count), .lock_fail_pulse(lock_fail_pulse)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: tracks the bit stream and where the next word ends
  int          m_left, m_mode, m_match, m_settle, m_slips;
  bit          m_wv, m_lfp, m_fco;
  logic [11:0] m_word, m_tail;

  // stream source
  int k, off;
  bit src_rand;

  // observed statistics
  int tcyc, last_wv, n_wv, n_gap13, n_gapbad, n_lfp;

  function automatic bit stream_bit();
    logic [11:0] pv;
    pv = PAT;
    if (src_rand) return bit'($urandom % 2);
    return pv[11 - ((k + 12 - off) % 12)];
  endfunction

  task automatic model_reset();
    m_left = DW; m_mode = MH; m_match = 0; m_settle = 0; m_slips = 0;
    m_wv = 0; m_lfp = 0; m_fco = 0; m_word = '0; m_tail = '0;
    k = 0; tcyc = 0; last_wv = -1; n_wv = 0; n_gap13 = 0; n_gapbad = 0; n_lfp = 0;
  endtask

  task automatic step_model(input bit b, input bit f, input bit ten, input bit rl);
    bit slp;
    slp = 0;
    if (m_wv && ten && !rl) begin
      if (m_mode == MH) begin
        if (m_word == PAT) begin m_match = 1; m_mode = (MC == 1) ? ML : MV; end
        else slp = 1;
      end else if (m_mode == MS) begin
        m_settle++;
        if (m_settle >= SS) m_mode = MH;
      end else if (m_mode == MV) begin
        if (m_word == PAT) begin m_match++; if (m_match >= MC) m_mode = ML; end
        else slp = 1;
      end
    end
    if (slp) begin m_mode = MS; m_settle = 0; m_match = 0; end
    if (rl) begin m_mode = MH; m_settle = 0; m_match = 0; end
    m_lfp = slp && (m_slips == DW - 1);
    if (slp) m_slips = (m_slips + 1) % DW;
    m_tail = {m_tail[10:0], b};
    m_fco  = f;
    // a slip costs one extra bit before the next word completes
    if (!slp) m_left--;
    m_wv = 0;
    if (m_left == 0) begin m_wv = 1; m_word = m_tail; m_left = DW; end
  endtask

  task automatic check_all();
    chk("word_valid", 32'(word_valid), 32'(m_wv));
    chk("word_out", 32'(word_out), 32'(m_word));
    chk("fco_out", 32'(fco_out), 32'(m_fco));
    chk("locked", 32'(locked), 32'(m_mode == ML));
    chk("slip_count", 32'(slip_count), 32'(m_slips));
    chk("lock_fail_pulse", 32'(lock_fail_pulse), 32'(m_lfp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wv"}, 32'(word_valid), 32'd0);
    chk({tag, "_word"}, 32'(word_out), 32'd0);
    chk({tag, "_fco"}, 32'(fco_out), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_slips"}, 32'(slip_count), 32'd0);
    chk({tag, "_lfp"}, 32'(lock_fail_pulse), 32'd0);
  endtask

  task automatic cyc(input bit ten, input bit rl);
    bit b, f;
    b = stream_bit();
    f = bit'($urandom % 2);
    ser_in = b; fco_in = f; train_en = ten; relock = rl;
    step_model(b, f, ten, rl);
    @(negedge dco_clk);
    check_all();
    k++; tcyc++;
    if (word_valid) begin
      n_wv++;
      if (last_wv >= 0) begin
        if (tcyc - last_wv == 13) n_gap13++;
        else if (tcyc - last_wv != 12) n_gapbad++;
      end
      last_wv = tcyc;
    end
    if (lock_fail_pulse) n_lfp++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; relock = 1'b0; train_en = 1'b0; ser_in = 1'b0; fco_in = 1'b1;
    repeat (2) @(negedge dco_clk);
    check_zero("rst");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int t, n_at_lock, wait_cyc, t_rl;
    bit found;
    src_rand = 0; off = 0;
    model_reset();

    // aligned pattern: lock after 8 words, no slips
    do_reset();
    off = 0; src_rand = 0;
    t = 0;
    while (!locked && t < 300) begin cyc(1, 0); t++; end
    n_at_lock = n_wv;
    chk("a_locked", 32'(locked), 32'd1);
    chk("a_lock_wv", 32'(n_at_lock), 32'd8);
    chk("a_slips", 32'(slip_count), 32'd0);

    // relock on the same word as a mismatch: back to hunting, no slip
    src_rand = 1;
    found = 0;
    t = 0;
    while (!found && t < 200) begin
      if (m_wv && m_word != PAT) begin
        t_rl = last_wv;
        cyc(1, 1);
        found = 1;
      end else begin
        cyc(1, 0);
      end
      t++;
    end
    chk("d_relock_hit", 32'(found), 32'd1);
    chk("d_locked", 32'(locked), 32'd0);
    chk("d_slips", 32'(slip_count), 32'd0);
    t = 0;
    while (last_wv == t_rl && t < 30) begin cyc(1, 0); t++; end
    chk("d_gap", 32'(last_wv - t_rl), 32'd12);

    // stream 5 bits early: five 13-cycle gaps, then lock on the pattern
    do_reset();
    off = 5; src_rand = 0;
    t = 0;
    while (!locked && t < 700) begin cyc(1, 0); t++; end
    chk("b_locked", 32'(locked), 32'd1);
    chk("b_slips", 32'(slip_count), 32'd5);
    chk("b_gap13", 32'(n_gap13), 32'd5);
    chk("b_gapbad", 32'(n_gapbad), 32'd0);
    t = 0;
    wait_cyc = n_wv;
    while (n_wv == wait_cyc && t < 30) begin cyc(1, 0); t++; end
    chk("b_word", 32'(word_out), 32'(PAT));

    // random data: slip_count wraps once, never locks
    do_reset();
    src_rand = 1;
    repeat (700) cyc(1, 0);
    chk("c_lfp_once", 32'(n_lfp), 32'd1);
    chk("c_locked", 32'(locked), 32'd0);

    // training disabled: words every 12 cycles, FSM frozen
    do_reset();
    off = 3; src_rand = 0;
    repeat (150) cyc(0, 0);
    chk("e_wv_count", 32'(n_wv), 32'd12);
    chk("e_gap13", 32'(n_gap13 + n_gapbad), 32'd0);
    chk("e_slips", 32'(slip_count), 32'd0);
    chk("e_locked", 32'(locked), 32'd0);

    // reset mid-verify: outputs clear at once, first word 12 cycles later
    do_reset();
    off = 0; src_rand = 0;
    t = 0;
    while (n_wv < 4 && t < 100) begin cyc(1, 0); t++; end
    #3 rst_n = 1'b0;
    #1 check_zero("f_async");
    @(negedge dco_clk);
    rst_n = 1'b1;
    model_reset();
    wait_cyc = 0;
    while (n_wv == 0 && wait_cyc < 30) begin cyc(1, 0); wait_cyc++; end
    chk("f_first_wv", 32'(wait_cyc), 32'd12);

    // mixed random traffic with sporadic train_en drops and relocks
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) begin
        src_rand = bit'($urandom % 2);
        off = int'($urandom % 12);
      end
      cyc(($urandom % 8) != 0, ($urandom % 60) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
